// File: rtl/ppl_frame_ctrl.sv
// ppl_frame_ctrl: per-frame scheduler for the ray-march pipeline entry slot.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   frame_req, frame_abort   start a frame / stop issuing and drain
//   p_pos_*, p_angle_*       live player pose, sampled once per frame
//   ret_*                    ray returning from the march stage
//   cam_*                    frame-latched pose
//   scan_rst                 clear to the viewport scanner
//   next_en, scanner_stop    entry-slot select: recirculate / inject / bubble
//   pix_we, pix_addr, pix_hit  registered retire to the pixel writer
//   busy, frame_done         activity flag, completion pulse
module ppl_frame_ctrl #(
  parameter int H_DISP    = 1280,
  parameter int V_DISP    = 720,
  parameter int MAX_STEPS = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_req,
  input  logic               frame_abort,
  input  logic        [15:0] p_pos_x,
  input  logic        [15:0] p_pos_y,
  input  logic        [15:0] p_pos_z,
  input  logic signed [15:0] p_angle_x,
  input  logic signed [15:0] p_angle_y,
  input  logic               ret_valid,
  input  logic               ret_hit,
  input  logic        [5:0]  ret_block_cnt,
  input  logic        [19:0] ret_pixel_addr,
  output logic        [15:0] cam_pos_x,
  output logic        [15:0] cam_pos_y,
  output logic        [15:0] cam_pos_z,
  output logic signed [15:0] cam_angle_x,
  output logic signed [15:0] cam_angle_y,
  output logic               scan_rst,
  output logic               next_en,
  output logic               scanner_stop,
  output logic               pix_we,
  output logic        [19:0] pix_addr,
  output logic               pix_hit,
  output logic               busy,
  output logic               frame_done
);
  localparam logic [19:0] NPIX = 20'(H_DISP * V_DISP);
  typedef enum logic [2:0] {IDLE, LATCH, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [19:0] r_issued, r_retired, r_in_flight;
  logic w_term, w_active, w_recirc, w_inject, w_retire;
  assign w_term   = ret_valid && (ret_hit || ret_block_cnt >= 6'(MAX_STEPS));
  assign w_active = r_state == RUN || r_state == DRAIN;
  // a still-marching return owns the slot ahead of any new ray
  assign w_recirc = w_active && ret_valid && !w_term;
  assign w_inject = r_state == RUN && !w_recirc && r_issued < NPIX;
  assign w_retire = w_active && w_term;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = frame_req ? LATCH : IDLE;
      LATCH:   w_next = RUN;
      // completion wins over a coincident abort
      RUN:     w_next = (w_retire && r_retired + 20'd1 == NPIX) ? DONE : frame_abort ? DRAIN : RUN;
      DRAIN:   w_next = (r_in_flight == '0) ? IDLE : DRAIN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    scan_rst     = r_state == LATCH;
    busy         = r_state != IDLE;
    frame_done   = r_state == DONE;
    next_en      = !w_recirc;
    scanner_stop = !(w_recirc || w_inject);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_pos_x   <= '0;
      cam_pos_y   <= '0;
      cam_pos_z   <= '0;
      cam_angle_x <= '0;
      cam_angle_y <= '0;
      r_issued    <= '0;
      r_retired   <= '0;
      r_in_flight <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_hit     <= 1'b0;
    end else begin
      pix_we <= w_retire;
      if (w_retire) begin
        pix_addr <= ret_pixel_addr;
        pix_hit  <= ret_hit;
      end
      if (r_state == LATCH) begin
        cam_pos_x   <= p_pos_x;
        cam_pos_y   <= p_pos_y;
        cam_pos_z   <= p_pos_z;
        cam_angle_x <= p_angle_x;
        cam_angle_y <= p_angle_y;
        r_issued    <= '0;
        r_retired   <= '0;
        r_in_flight <= '0;
      end else if (w_active) begin
        r_issued    <= r_issued + 20'(w_inject);
        r_retired   <= r_retired + 20'(w_retire);
        r_in_flight <= r_in_flight + 20'(w_inject) - 20'(w_retire);
      end
    end
  end
endmodule

// File: tb/tb_ppl_frame_ctrl.sv
// tb_ppl_frame_ctrl: vector table, directed corner sequences and a closed-loop random march stage for ppl_frame_ctrl.
module tb_ppl_frame_ctrl;
  localparam int H = 4, V = 2, NPIX = H * V, MS = 40;
  logic clk = 0, rst = 1, frame_req = 0, frame_abort = 0;
  logic [15:0] p_pos_x = 16'h1111, p_pos_y = 16'h2222, p_pos_z = 16'h3333;
  logic signed [15:0] p_angle_x = -16'sd5, p_angle_y = 16'sd7;
  logic ret_valid = 0, ret_hit = 0;
  logic [5:0] ret_block_cnt = 0;
  logic [19:0] ret_pixel_addr = 0;
  logic [15:0] cam_pos_x, cam_pos_y, cam_pos_z;
  logic signed [15:0] cam_angle_x, cam_angle_y;
  logic scan_rst, next_en, scanner_stop, pix_we, pix_hit, busy, frame_done;
  logic [19:0] pix_addr;
  int vecs = 0, errs = 0;
  logic exp_we = 0, exp_hit = 0;
  logic [19:0] exp_addr = 0;

  ppl_frame_ctrl #(.H_DISP(H), .V_DISP(V), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .frame_abort(frame_abort),
    .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
    .p_angle_x(p_angle_x), .p_angle_y(p_angle_y),
    .ret_valid(ret_valid), .ret_hit(ret_hit), .ret_block_cnt(ret_block_cnt),
    .ret_pixel_addr(ret_pixel_addr),
    .cam_pos_x(cam_pos_x), .cam_pos_y(cam_pos_y), .cam_pos_z(cam_pos_z),
    .cam_angle_x(cam_angle_x), .cam_angle_y(cam_angle_y),
    .scan_rst(scan_rst), .next_en(next_en), .scanner_stop(scanner_stop),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_hit(pix_hit),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ab, v, h;
    logic [5:0] c;
    logic [19:0] a;
    logic ne, st, we, ph, bz;
  } row_t;
  row_t tbl [14];

  typedef struct {
    logic v, hf;
    logic [19:0] a;
    int c, tgt;
  } ray_t;

  function automatic row_t mk(input int ab, v, h, c, a, ne, st, we, ph, bz);
    mk = '{ab[0], v[0], h[0], c[5:0], a[19:0], ne[0], st[0], we[0], ph[0], bz[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " pix_we"}, pix_we, 0);
    chk({tag, " pix_addr"}, pix_addr, 0);
    chk({tag, " pix_hit"}, pix_hit, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " scan_rst"}, scan_rst, 0);
    chk({tag, " next_en"}, next_en, 1);
    chk({tag, " scanner_stop"}, scanner_stop, 1);
    chk({tag, " cam_pos_x"}, cam_pos_x, 0);
    chk({tag, " cam_angle_x"}, cam_angle_x, 0);
  endtask

  task automatic chk_cam(input string tag, input logic [15:0] x, y, z, input logic signed [15:0] ax, ay);
    chk({tag, " cam_pos_x"}, cam_pos_x, x);
    chk({tag, " cam_pos_y"}, cam_pos_y, y);
    chk({tag, " cam_pos_z"}, cam_pos_z, z);
    chk({tag, " cam_angle_x"}, cam_angle_x, ax);
    chk({tag, " cam_angle_y"}, cam_angle_y, ay);
  endtask

  task automatic start_frame;
    frame_req = 1;
    tick();
    frame_req = 0;
    #1 chk("scan_rst in latch", scan_rst, 1);
    tick();
  endtask

  // closed-loop frame: the bench plays scanner and march stage, and predicts
  // every slot decision and retire from the counting rules
  task automatic run_frame(input int f);
    ray_t pipe [8];
    ray_t e;
    int lat, phase, req_left, abort_at, rc, step_max, done_seen, completed;
    int m_issued, m_retired, scan, nfl, ones;
    int seen [NPIX];
    logic [15:0] cx, cy, cz;
    logic signed [15:0] cax, cay;
    bit started, term, recirc, inj, act;
    lat = (f == 0) ? 3 : int'($urandom_range(2, 6));
    step_max = (f == 1) ? 1 : 8;
    abort_at = (f % 3 == 2) ? int'($urandom_range(0, 10)) : -1;
    req_left = $urandom_range(1, 3);
    phase = 0; rc = 0; done_seen = 0; completed = 0; m_issued = 0; m_retired = 0; scan = 0;
    started = 0; cx = 0; cy = 0; cz = 0; cax = 0; cay = 0;
    foreach (seen[i]) seen[i] = 0;
    for (int i = 0; i < 8; i++) pipe[i] = '{v: 0, hf: 0, a: 0, c: 0, tgt: 0};
    for (int cyc = 0; cyc < 3000 && !(started && phase == 0); cyc++) begin
      chk("pix_we", pix_we, exp_we);
      if (exp_we) begin
        chk("pix_addr", pix_addr, exp_addr);
        chk("pix_hit", pix_hit, exp_hit);
      end
      if (phase >= 2) chk_cam("frame pose", cx, cy, cz, cax, cay);
      e = pipe[lat-1];
      nfl = 0;
      for (int i = 0; i < lat; i++) nfl += int'(pipe[i].v);
      ret_valid = e.v;
      ret_hit = e.v && e.hf && e.c >= e.tgt;
      ret_block_cnt = 6'(e.c);
      ret_pixel_addr = e.a;
      frame_req = req_left > 0;
      if (req_left > 0) req_left--;
      frame_abort = (phase == 2) ? (rc == abort_at) : ($urandom_range(0, 3) == 0);
      p_pos_x = 16'($urandom); p_pos_y = 16'($urandom); p_pos_z = 16'($urandom);
      p_angle_x = 16'($urandom); p_angle_y = 16'($urandom);
      #1;
      act = phase == 2 || phase == 3;
      term = ret_valid && (ret_hit || e.c >= MS);
      recirc = act && ret_valid && !term;
      inj = phase == 2 && !recirc && m_issued < NPIX;
      chk("next_en", next_en, !recirc);
      chk("scanner_stop", scanner_stop, !(recirc || inj));
      chk("busy", busy, phase != 0);
      chk("scan_rst", scan_rst, phase == 1);
      chk("frame_done", frame_done, phase == 4);
      if (frame_done) done_seen++;
      exp_we = act && term;
      if (exp_we) begin
        exp_addr = e.a;
        exp_hit = ret_hit;
        if (e.a < NPIX) seen[e.a]++;
        m_retired++;
      end
      if (recirc) begin
        e.c = e.c + int'($urandom_range(1, step_max));
        if (e.c > 63) e.c = 63;
      end else if (inj) begin
        e.v = 1;
        e.a = 20'(scan);
        e.c = $urandom_range(1, step_max);
        e.hf = (f == 0) ? 1'b1 : (f == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        e.tgt = (f == 0) ? 0 : int'($urandom_range(0, 50));
        scan++;
        m_issued++;
      end else e.v = 0;
      for (int i = lat - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = e;
      if (phase == 1) begin
        cx = p_pos_x; cy = p_pos_y; cz = p_pos_z; cax = p_angle_x; cay = p_angle_y;
        scan = 0;
      end
      case (phase)
        0: if (frame_req) begin phase = 1; started = 1; end
        1: phase = 2;
        2: begin
          rc++;
          if (exp_we && m_retired == NPIX) begin phase = 4; completed = 1; end
          else if (frame_abort) phase = 3;
        end
        3: if (nfl == 0) phase = 0;
        default: phase = 0;
      endcase
      tick();
    end
    frame_abort = 0;
    frame_req = 0;
    chk("frame back to idle within budget", phase, 0);
    chk("frame_done pulse count", done_seen, completed);
    if (completed != 0) begin
      ones = 0;
      foreach (seen[i]) ones += int'(seen[i] == 1);
      chk("injects per frame", m_issued, NPIX);
      chk("distinct retired addresses", ones, NPIX);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    //             ab v  h  cnt addr ne st we ph bz
    tbl[0]  = mk(0, 0, 0, 0,  0,  1, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 0, 39, 11, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 40, 12, 1, 0, 1, 0, 1);
    tbl[3]  = mk(0, 1, 1, 5,  13, 1, 0, 1, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0,  0,  1, 0, 0, 0, 1);
    tbl[5]  = mk(0, 1, 0, 0,  14, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0,  0,  1, 0, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 10, 15, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 1, 63, 20, 1, 1, 1, 1, 1);
    tbl[10] = mk(0, 1, 0, 45, 21, 1, 1, 1, 0, 1);
    tbl[11] = mk(0, 1, 1, 1,  22, 1, 1, 1, 1, 1);
    tbl[12] = mk(0, 0, 0, 0,  0,  1, 1, 0, 0, 1);
    tbl[13] = mk(0, 1, 1, 0,  23, 1, 1, 0, 0, 0);
    #2 check_reset("power-on");
    #10 rst = 0;
    tick();
    // table: miss boundary, hits, abort after 5 injects / 2 retires, drain of 3
    start_frame();
    chk_cam("latched pose", 16'h1111, 16'h2222, 16'h3333, -16'sd5, 16'sd7);
    p_pos_x = 16'hBEEF; p_angle_y = -16'sd100;
    for (int i = 0; i < 14; i++) begin
      frame_abort = tbl[i].ab; ret_valid = tbl[i].v; ret_hit = tbl[i].h;
      ret_block_cnt = tbl[i].c; ret_pixel_addr = tbl[i].a;
      #1;
      chk($sformatf("row%0d next_en", i), next_en, tbl[i].ne);
      chk($sformatf("row%0d scanner_stop", i), scanner_stop, tbl[i].st);
      chk($sformatf("row%0d busy", i), busy, tbl[i].bz);
      chk($sformatf("row%0d frame_done", i), frame_done, 0);
      tick();
      chk($sformatf("row%0d pix_we", i), pix_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("row%0d pix_addr", i), pix_addr, tbl[i].a);
        chk($sformatf("row%0d pix_hit", i), pix_hit, tbl[i].ph);
      end
    end
    frame_abort = 0; ret_valid = 0;
    chk_cam("pose held after mid-frame change", 16'h1111, 16'h2222, 16'h3333, -16'sd5, 16'sd7);
    // 10 cycles of recirculation, then exactly NPIX injects, then bubbles until final retire
    p_pos_x = 16'h0A0A; p_pos_y = 16'h0B0B; p_pos_z = 16'h0C0C; p_angle_x = 16'sd300; p_angle_y = -16'sd300;
    start_frame();
    for (int k = 0; k < 10; k++) begin
      ret_valid = 1; ret_hit = 0; ret_block_cnt = (k == 9) ? 6'd39 : 6'(k * 4); ret_pixel_addr = 20'(k);
      #1;
      chk("recirc next_en", next_en, 0);
      chk("recirc scanner_stop", scanner_stop, 0);
      tick();
    end
    ret_valid = 0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      #1 if (!scanner_stop) n++;
      tick();
    end
    chk("injects after recirculation", n, NPIX);
    for (int k = 0; k < NPIX; k++) begin
      ret_valid = 1; ret_hit = 1; ret_block_cnt = 0; ret_pixel_addr = 20'(k);
      #1;
      chk("bubble next_en", next_en, 1);
      chk("bubble scanner_stop", scanner_stop, 1);
      tick();
      chk("final retire pix_we", pix_we, 1);
      chk("final retire pix_addr", pix_addr, k);
      chk("frame_done on last retire", frame_done, k == NPIX - 1);
    end
    ret_valid = 0;
    chk("busy in done", busy, 1);
    chk_cam("recirc frame pose", 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'sd300, -16'sd300);
    tick();
    chk("busy after done", busy, 0);
    chk("frame_done single pulse", frame_done, 0);
    // asynchronous reset in the middle of RUN
    start_frame();
    tick();
    tick();
    ret_valid = 1; ret_hit = 1; ret_pixel_addr = 20'd5;
    tick();
    ret_valid = 0;
    chk("pix_we before reset", pix_we, 1);
    #2 rst = 1;
    #1 check_reset("async reset");
    #2 rst = 0;
    for (int f = 0; f < 6; f++) run_frame(f);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
